sprite_framebuffer_blitter: RTL

Writer-side counterpart of the per-pixel player sprite address generator. On a start pulse, it walks one 48x68 player sprite frame in sprite ROM and copies each opaque pixel into the single frame buffer at the player's screen position. It sits between the game-logic frame tick, which supplies position and direction, and the frame-buffer write port; the VGA scan-out path later reads the buffer.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/blit_coord_counter.sv | 52 +++++
 rtl/sprite_framebuffer_blitter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - player sprite and frame-buffer constants shared by blitter and scan-out
package sprite_pkg;

  localparam int PLAYER_W = 48;
  localparam int PLAYER_H = 68;
  localparam logic [20:0] RIGHT_OFFSET = 21'd0;
  localparam logic [20:0] LEFT_OFFSET = 21'd3264;
  localparam int FB_W = 640;
  localparam int FB_H = 480;
  localparam int PIXEL_W = 4;
  localparam logic [3:0] TRANSPARENT = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } blit_state_t;

endpackage

// File: rtl/blit_coord_counter.sv
// rtl/blit_coord_counter.sv - raster column/row walker over one sprite frame
import sprite_pkg::*;

module blit_coord_counter #(
  parameter int PLAYER_W = sprite_pkg::PLAYER_W,
  parameter int PLAYER_H = sprite_pkg::PLAYER_H,
  localparam int CW = $clog2(PLAYER_W),
  localparam int RW = $clog2(PLAYER_H + 1),
  localparam int IW = $clog2(PLAYER_W * PLAYER_H)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic [IW-1:0] o_idx,
  output logic          o_last
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [IW-1:0] r_idx;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == CW'(PLAYER_W - 1));
  assign w_row_last = (r_row == RW'(PLAYER_H - 1));

  // Raster order makes r*PLAYER_W + c equal to the pixel count, so the index just counts.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_col <= '0;
      r_row <= '0;
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= r_idx + 1'b1;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_idx  = r_idx;
  assign o_last = w_col_last && w_row_last;

endmodule

// File: rtl/sprite_framebuffer_blitter.sv
// rtl/sprite_framebuffer_blitter.sv - copies opaque sprite ROM pixels into the frame buffer
import sprite_pkg::*;

module sprite_framebuffer_blitter #(
  parameter int                   PLAYER_W     = sprite_pkg::PLAYER_W,
  parameter int                   PLAYER_H     = sprite_pkg::PLAYER_H,
  parameter logic [20:0]          RIGHT_OFFSET = sprite_pkg::RIGHT_OFFSET,
  parameter logic [20:0]          LEFT_OFFSET  = sprite_pkg::LEFT_OFFSET,
  parameter int                   FB_W         = sprite_pkg::FB_W,
  parameter int                   FB_H         = sprite_pkg::FB_H,
  parameter int                   PIXEL_W      = sprite_pkg::PIXEL_W,
  parameter logic [PIXEL_W-1:0]   TRANSPARENT  = sprite_pkg::TRANSPARENT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [9:0]         PlayerX,
  input  logic [9:0]         PlayerY,
  input  logic               playerDirection,
  output logic               busy,
  output logic               done,
  output logic [20:0]        romAddress,
  input  logic [PIXEL_W-1:0] romData,
  output logic               fbWe,
  output logic [18:0]        fbAddress,
  output logic [PIXEL_W-1:0] fbData,
  input  logic               fbReady
);

  localparam int CW = $clog2(PLAYER_W);
  localparam int RW = $clog2(PLAYER_H + 1);
  localparam int IW = $clog2(PLAYER_W * PLAYER_H);

  blit_state_t   r_state;
  blit_state_t   w_next;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [20:0]   r_base;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [IW-1:0] w_idx;
  logic          w_last;
  logic          w_clear;
  logic          w_advance;
  logic          w_write_req;
  logic [10:0]   w_x11;
  logic [10:0]   w_y11;
  logic [18:0]   w_fb_lin;

  blit_coord_counter #(
    .PLAYER_W(PLAYER_W),
    .PLAYER_H(PLAYER_H)
  ) u_coord (
    .i_clk    (Clk),
    .i_reset  (Reset),
    .i_clear  (w_clear),
    .i_advance(w_advance),
    .o_col    (w_col),
    .o_row    (w_row),
    .o_idx    (w_idx),
    .o_last   (w_last)
  );

  // 11-bit screen coordinates so a sprite hanging past the right/bottom edge never wraps.
  assign w_x11    = 11'(r_x) + 11'(w_col);
  assign w_y11    = 11'(r_y) + 11'(w_row);
  assign w_fb_lin = 19'(w_y11) * 19'(FB_W) + 19'(w_x11);

  assign w_clear     = (r_state == ST_IDLE) && start;
  assign w_write_req = (r_state == ST_WRITE) && (w_x11 < 11'(FB_W)) &&
                       (w_y11 < 11'(FB_H)) && (romData != TRANSPARENT);
  assign w_advance   = (r_state == ST_WRITE) && (!w_write_req || fbReady);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_x    <= PlayerX;
        r_y    <= PlayerY;
        r_base <= playerDirection ? LEFT_OFFSET : RIGHT_OFFSET;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    done       = 1'b0;
    romAddress = '0;
    fbWe       = 1'b0;
    fbAddress  = '0;
    fbData     = '0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_READ;
      end
      ST_READ: begin
        romAddress = r_base + 21'(w_idx);
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        romAddress = r_base + 21'(w_idx);
        w_next     = ST_WRITE;
      end
      ST_WRITE: begin
        // Address stays put while a write is pending, so romData stays valid too.
        romAddress = r_base + 21'(w_idx);
        fbWe       = w_write_req;
        fbAddress  = w_write_req ? w_fb_lin : 19'd0;
        fbData     = w_write_req ? romData : '0;
        if (w_advance) w_next = w_last ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule
